// File: rtl/pri_mem_pkg.sv
// Shared types and defaults for the priRV32 memory arbiter slice.
//   owner_e         : owner of the response due in the next cycle
//   ADDR_W_DEF      : default byte address width
//   DATA_W_DEF      : default data width (4 byte lanes)
//   STARVE_MAX_DEF  : default IFU denial limit before a forced fetch grant
//   STARVE_CNT_W    : width of the starvation counter (limit range 1..15)
package pri_mem_pkg;

  localparam int unsigned ADDR_W_DEF     = 32;
  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned STARVE_MAX_DEF = 4;
  localparam int unsigned STARVE_CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IF   = 2'd1,
    LS   = 2'd2
  } owner_e;

endpackage

// File: rtl/pri_mem_arbiter_if.sv
// Bus bundle between IFU, LSU, the arbiter and the SRAM macro.
//   slave  : arbiter view (takes requests and mem_rdata, drives grants,
//            responses and the SRAM command)
//   master : requester/memory view (the mirror image)
interface pri_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [3:0]        ls_be;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;

  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, if_flush,
    output if_gnt, if_rvalid, if_rdata,
    input  ls_req, ls_we, ls_be, ls_addr, ls_wdata,
    output ls_gnt, ls_rvalid, ls_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr, if_flush,
    input  if_gnt, if_rvalid, if_rdata,
    output ls_req, ls_we, ls_be, ls_addr, ls_wdata,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/pri_starve_ctr.sv
// Counts consecutive cycles in which the IFU requests but is not granted.
//   clk, rst_n : clock, asynchronous active-low reset
//   if_req     : IFU request
//   if_gnt     : IFU grant this cycle
//   starved    : limit reached while the IFU is still requesting
module pri_starve_ctr
  import pri_mem_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req,
  input  logic if_gnt,
  output logic starved
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_MAX);

  logic [STARVE_CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!if_req || if_gnt) begin
      cnt <= '0;
    end else if (cnt != LIMIT) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign starved = if_req && (cnt == LIMIT);

endmodule

// File: rtl/pri_mem_arbiter.sv
// Single-port SRAM arbiter between the priRV32 IFU and LSU.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pri_mem_arbiter_if.slave carrying IFU request/response,
//                LSU request/response and the SRAM command/read data
// LSU has priority unless the IFU has been denied STARVE_MAX cycles in a
// row. Grants are combinational; the read response returns one cycle later
// and is steered by the registered owner.
module pri_mem_arbiter
  import pri_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input logic                  clk,
  input logic                  rst_n,
  pri_mem_arbiter_if.slave     bus
);

  owner_e            resp_owner;
  logic              resp_store;
  logic              starved;
  logic              ls_win;
  logic              if_win;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;
  logic [3:0]        we_mux;

  pri_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk     (clk),
    .rst_n   (rst_n),
    .if_req  (bus.if_req),
    .if_gnt  (if_win),
    .starved (starved)
  );

  // rst_n gates the grants so the SRAM command drops the instant reset asserts.
  always_comb begin
    ls_win    = rst_n && bus.ls_req && !starved;
    if_win    = rst_n && bus.if_req && !ls_win;
    addr_mux  = '0;
    wdata_mux = '0;
    we_mux    = '0;
    if (if_win) begin
      addr_mux = bus.if_addr;
    end else if (ls_win) begin
      addr_mux  = bus.ls_addr;
      wdata_mux = bus.ls_wdata;
      we_mux    = bus.ls_we ? bus.ls_be : 4'b0000;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_owner <= IDLE;
      resp_store <= 1'b0;
    end else if (ls_win) begin
      resp_owner <= LS;
      resp_store <= bus.ls_we;
    end else if (if_win) begin
      resp_owner <= IF;
      resp_store <= 1'b0;
    end else begin
      resp_owner <= IDLE;
      resp_store <= 1'b0;
    end
  end

  logic if_rvalid_c;
  logic ls_rvalid_c;

  always_comb begin
    if_rvalid_c = (resp_owner == IF) && !bus.if_flush;
    ls_rvalid_c = (resp_owner == LS);
  end

  assign bus.if_gnt    = if_win;
  assign bus.ls_gnt    = ls_win;
  assign bus.mem_en    = if_win || ls_win;
  assign bus.mem_we    = we_mux;
  assign bus.mem_addr  = addr_mux;
  assign bus.mem_wdata = wdata_mux;

  assign bus.if_rvalid = if_rvalid_c;
  assign bus.if_rdata  = if_rvalid_c ? bus.mem_rdata : '0;
  assign bus.ls_rvalid = ls_rvalid_c;
  assign bus.ls_rdata  = (ls_rvalid_c && !resp_store) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_pri_mem_arbiter.sv
// Directed bench for pri_mem_arbiter with a small one-cycle-latency SRAM.
// SRAM word i is preloaded with 32'hC0DE_0000 | i.
module tb_pri_mem_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  pri_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  pri_mem_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:255];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | i;
    bus.mem_rdata = '0;
  end

  always @(posedge clk) begin
    if (bus.mem_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_we[b]) mem[bus.mem_addr[9:2]][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
      bus.mem_rdata <= mem[bus.mem_addr[9:2]];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic quiet();
    bus.if_req = 0; bus.if_addr = '0; bus.if_flush = 0;
    bus.ls_req = 0; bus.ls_we = 0; bus.ls_be = '0; bus.ls_addr = '0; bus.ls_wdata = '0;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic ls_load(input logic [31:0] a);
    bus.ls_req = 1; bus.ls_we = 0; bus.ls_be = 4'b0000; bus.ls_addr = a;
  endtask

  initial begin
    logic exp_ls [0:6];
    logic exp_if [0:6];
    checks = 0;
    errors = 0;
    quiet();
    rst_n = 0;

    // reset with both requests asserted: everything zero
    bus.if_req = 1; bus.ls_req = 1;
    #1;
    check("rst_if_gnt", bus.if_gnt, 0);
    check("rst_ls_gnt", bus.ls_gnt, 0);
    check("rst_mem_en", bus.mem_en, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_rvalid", {bus.if_rvalid, bus.ls_rvalid}, 0);
    cyc(); quiet(); rst_n = 1;
    cyc();

    // IFU-only fetches 0x00, 0x04, 0x08
    bus.if_req = 1; bus.if_addr = 32'h0; #1;
    check("f0_if_gnt", bus.if_gnt, 1);
    check("f0_mem_en", bus.mem_en, 1);
    check("f0_mem_addr", bus.mem_addr, 32'h0);
    check("f0_if_rvalid", bus.if_rvalid, 0);
    cyc(); bus.if_addr = 32'h4; #1;
    check("f1_if_gnt", bus.if_gnt, 1);
    check("f1_mem_addr", bus.mem_addr, 32'h4);
    check("f1_if_rvalid", bus.if_rvalid, 1);
    check("f1_if_rdata", bus.if_rdata, 32'hC0DE0000);
    check("f1_ls_quiet", {bus.ls_gnt, bus.ls_rvalid}, 0);
    cyc(); bus.if_addr = 32'h8; #1;
    check("f2_if_rdata", bus.if_rdata, 32'hC0DE0001);
    cyc(); quiet(); #1;
    check("f3_mem_en", bus.mem_en, 0);
    check("f3_if_rvalid", bus.if_rvalid, 1);
    check("f3_if_rdata", bus.if_rdata, 32'hC0DE0002);
    check("f3_ls_rdata", bus.ls_rdata, 0);
    cyc(); #1;
    check("f4_if_rvalid", bus.if_rvalid, 0);
    check("f4_if_rdata", bus.if_rdata, 0);

    // starvation: both requesters held, LSU 0-3, IFU 4, LSU 5-6
    exp_ls = '{1, 1, 1, 1, 0, 1, 1};
    exp_if = '{0, 0, 0, 0, 1, 0, 0};
    for (int i = 0; i < 7; i++) begin
      cyc();
      ls_load(32'h100); bus.if_req = 1; bus.if_addr = 32'h10; #1;
      check($sformatf("stv%0d_ls_gnt", i), bus.ls_gnt, exp_ls[i]);
      check($sformatf("stv%0d_if_gnt", i), bus.if_gnt, exp_if[i]);
      if (i == 1) check("stv1_ls_rdata", bus.ls_rdata, 32'hC0DE0040);
      if (i == 5) check("stv5_if_rdata", bus.if_rdata, 32'hC0DE0004);
      if (i == 5) check("stv5_ls_rvalid", bus.ls_rvalid, 0);
    end
    cyc(); quiet(); #1;
    check("stv_tail_ls_rvalid", bus.ls_rvalid, 1);
    check("stv_tail_mem_en", bus.mem_en, 0);

    // partial store then load back
    cyc();
    bus.ls_req = 1; bus.ls_we = 1; bus.ls_be = 4'b0011;
    bus.ls_addr = 32'h100; bus.ls_wdata = 32'hDEADBEEF; #1;
    check("st_ls_gnt", bus.ls_gnt, 1);
    check("st_mem_we", bus.mem_we, 4'b0011);
    check("st_mem_addr", bus.mem_addr, 32'h100);
    check("st_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    cyc(); ls_load(32'h100); bus.ls_wdata = '0; #1;
    check("st_ack_rvalid", bus.ls_rvalid, 1);
    check("st_ack_rdata", bus.ls_rdata, 0);
    check("ld_mem_we", bus.mem_we, 0);
    check("ld_mem_wdata", bus.mem_wdata, 0);
    cyc(); quiet(); #1;
    check("ld_rvalid", bus.ls_rvalid, 1);
    check("ld_rdata", bus.ls_rdata, 32'hC0DEBEEF);

    // flush kills only the previous cycle's fetch response
    cyc(); bus.if_req = 1; bus.if_addr = 32'h0; #1;
    check("fl0_if_gnt", bus.if_gnt, 1);
    cyc(); bus.if_addr = 32'h4; bus.if_flush = 1; #1;
    check("fl1_if_gnt", bus.if_gnt, 1);
    check("fl1_if_rvalid", bus.if_rvalid, 0);
    check("fl1_if_rdata", bus.if_rdata, 0);
    cyc(); quiet(); #1;
    check("fl2_if_rvalid", bus.if_rvalid, 1);
    check("fl2_if_rdata", bus.if_rdata, 32'hC0DE0001);
    // flush while LSU owns the response has no effect
    cyc(); ls_load(32'h8); #1;
    cyc(); quiet(); bus.if_flush = 1; #1;
    check("fl_ls_rvalid", bus.ls_rvalid, 1);
    check("fl_ls_rdata", bus.ls_rdata, 32'hC0DE0002);
    check("fl_ls_if_rvalid", bus.if_rvalid, 0);

    // reset in the cycle after a load grant, with the counter at the limit
    for (int i = 0; i < 4; i++) begin
      cyc(); quiet(); ls_load(32'h100); bus.if_req = 1; bus.if_addr = 32'h0; #1;
      check($sformatf("pre_rst%0d_ls_gnt", i), bus.ls_gnt, 1);
    end
    cyc(); rst_n = 0; #1;
    check("arst_ls_gnt", bus.ls_gnt, 0);
    check("arst_if_gnt", bus.if_gnt, 0);
    check("arst_mem_en", bus.mem_en, 0);
    check("arst_mem_addr", bus.mem_addr, 0);
    check("arst_ls_rvalid", bus.ls_rvalid, 0);
    check("arst_ls_rdata", bus.ls_rdata, 0);
    cyc(); quiet(); rst_n = 1; #1;
    check("post_rst_ls_rvalid", bus.ls_rvalid, 0);
    cyc(); ls_load(32'h100); bus.if_req = 1; #1;
    check("post_rst_cnt_ls_gnt", bus.ls_gnt, 1);
    check("post_rst_cnt_if_gnt", bus.if_gnt, 0);
    cyc(); quiet();
    cyc();

    // idle: nothing happens for 10 cycles
    for (int i = 0; i < 10; i++) begin
      cyc(); #1;
      check($sformatf("idle%0d_mem_en", i), bus.mem_en, 0);
      check($sformatf("idle%0d_mem_we", i), bus.mem_we, 0);
      check($sformatf("idle%0d_rvalid", i), {bus.if_rvalid, bus.ls_rvalid}, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pri_mem_arbiter.md
# pri_mem_arbiter

Single-port memory arbiter sharing one synchronous SRAM between the priRV32 instruction fetch unit (IFU) and the load/store unit (LSU). It grants at most one request per cycle, routes the one-cycle-latency read response back to the owner, and prevents IFU starvation under continuous data traffic. It sits between `priRV32_IFU`/LSU and the on-chip memory macro.

## Interface
Parameters:
- `ADDR_W`, 32, byte address width
- `DATA_W`, 32, data width (fixed 4 byte lanes)
- `STARVE_MAX`, 4, consecutive IFU denials that force an IFU grant (1..15)

Ports (reset is asynchronous and active-low; one clock):
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `if_req`  in  1  IFU fetch request, held until granted
- `if_addr`  in  ADDR_W  fetch address, word aligned
- `if_flush`  in  1  IFU redirect; kills the IFU response due this cycle
- `if_gnt`  out  1  fetch accepted this cycle (combinational)
- `if_rvalid`  out  1  fetch data valid
- `if_rdata`  out  DATA_W  fetch data
- `ls_req`  in  1  LSU request, held until granted
- `ls_we`  in  1  1 = store, 0 = load
- `ls_be`  in  4  store byte enables
- `ls_addr`  in  ADDR_W  data address
- `ls_wdata`  in  DATA_W  store data
- `ls_gnt`  out  1  LSU request accepted (combinational)
- `ls_rvalid`  out  1  load data / store ack valid
- `ls_rdata`  out  DATA_W  load data; 0 on store ack
- `mem_en`  out  1  SRAM access enable
- `mem_we`  out  4  SRAM byte write enables
- `mem_addr`  out  ADDR_W  SRAM address
- `mem_wdata`  out  DATA_W  SRAM write data
- `mem_rdata`  in  DATA_W  SRAM read data, valid one cycle after `mem_en`

## Operation
- Grant rule per cycle: if `ls_req` and not starved -> LSU; else if `if_req` -> IFU; else none. Starved = `starve_cnt == STARVE_MAX` and `if_req`.
- `starve_cnt`: increments (saturating at STARVE_MAX) each cycle `if_req` is high and IFU not granted; clears when IFU granted or `if_req` low.
- Memory drive: granted side's address/data appear on `mem_*` in the grant cycle; `mem_en` = `if_gnt | ls_gnt`; `mem_we` = `ls_be` only for LSU store grant, else 0. No grant -> `mem_we` = 0, `mem_addr`/`mem_wdata` = 0.
- Owner register `resp_owner` in {IDLE, IF, LS} latches the granted side each cycle (IDLE if none).
- Response cycle (owner from previous cycle): IF -> `if_rvalid`=1, `if_rdata`=`mem_rdata`, unless `if_flush` high this cycle (then `if_rvalid`=0). LS -> `ls_rvalid`=1; `ls_rdata`=`mem_rdata` for load, 0 for store (store flag latched with owner).
- `if_rdata`/`ls_rdata` read 0 whenever the respective rvalid is 0.
- Back-to-back grants allowed every cycle; fully pipelined, one outstanding response per cycle.

## Timing
- Grant: combinational, same cycle as request. Response: exactly 1 cycle after grant.
- Reset (`rst_n` low, any time): all outputs 0 immediately, including combinational grants; `resp_owner`=IDLE, `starve_cnt`=0. A response pending at reset is dropped, never delivered.
- Simultaneous `if_req` and `ls_req`, counter < STARVE_MAX: LSU wins. Counter == STARVE_MAX: IFU wins, counter clears next edge.
- `if_flush` in cycle N affects only the response of an IFU grant in cycle N-1; an IFU grant in cycle N itself is unaffected. Flush with owner LS/IDLE: no effect.
- Requests dropped before grant are legal; no state retained.

## Structure
- Shared package `pri_mem_pkg`: `owner_e` enum (IDLE, IF, LS), default `STARVE_MAX`, `ADDR_W`/`DATA_W` constants.
- One sub-module natural: `pri_starve_ctr` (saturating counter with clear, `starved` output).

## Test plan
- Reset then IFU-only fetches of 0x00, 0x04, 0x08 on consecutive cycles -> `if_gnt` each cycle, `if_rvalid` with SRAM words one cycle later, `ls_*` quiet.
- Continuous `ls_req` loads and `if_req` held from cycle 0, STARVE_MAX=4 -> LSU granted cycles 0-3, IFU granted cycle 4, LSU resumes cycle 5.
- LSU store 0xDEADBEEF to 0x100 with `ls_be`=4'b0011, then load 0x100 -> `mem_we`=4'b0011, store ack with `ls_rdata`=0, load returns lower half updated only.
- IFU grant at cycle N, `if_flush` at N+1 -> `if_rvalid`=0 at N+1; IFU grant at N+1 with flush at N+1 -> its response at N+2 delivered.
- `rst_n` asserted low in the cycle after an LSU load grant -> `ls_rvalid` never asserts; all outputs 0 asynchronously; counter 0 after release.
- Both requesters idle -> `mem_en`=0, `mem_we`=0, no rvalid for 10 cycles.
